// File: rtl/vx_tex_req_arb.sv
// vx_tex_req_arb: per-input texture request FIFOs drained round-robin into one registered
// output slot; each output request carries the index of the input it came from.
module vx_tex_req_arb #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_THREADS = 4,
  parameter int UUID_BITS   = 44,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int NTEX_BITS   = 1,
  parameter int QUEUE_DEPTH = 4,
  localparam int SRC_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_INPUTS-1:0]                         in_valid,
  input  logic [NUM_INPUTS-1:0][UUID_BITS-1:0]          in_uuid,
  input  logic [NUM_INPUTS-1:0][NW_BITS-1:0]            in_wid,
  input  logic [NUM_INPUTS-1:0][NUM_THREADS-1:0]        in_tmask,
  input  logic [NUM_INPUTS-1:0][31:0]                   in_PC,
  input  logic [NUM_INPUTS-1:0][NR_BITS-1:0]            in_rd,
  input  logic [NUM_INPUTS-1:0]                         in_wb,
  input  logic [NUM_INPUTS-1:0][NTEX_BITS-1:0]          in_unit,
  input  logic [NUM_INPUTS-1:0][1:0][NUM_THREADS-1:0][31:0] in_coords,
  input  logic [NUM_INPUTS-1:0][NUM_THREADS-1:0][31:0]  in_lod,
  output logic [NUM_INPUTS-1:0]                         in_ready,
  output logic                                          out_valid,
  output logic [SRC_W-1:0]                              out_src,
  output logic [UUID_BITS-1:0]                          out_uuid,
  output logic [NW_BITS-1:0]                            out_wid,
  output logic [NUM_THREADS-1:0]                        out_tmask,
  output logic [31:0]                                   out_PC,
  output logic [NR_BITS-1:0]                            out_rd,
  output logic                                          out_wb,
  output logic [NTEX_BITS-1:0]                          out_unit,
  output logic [1:0][NUM_THREADS-1:0][31:0]             out_coords,
  output logic [NUM_THREADS-1:0][31:0]                  out_lod,
  input  logic                                          out_ready,
  output logic [31:0]                                   perf_stalls
);

  localparam int PW    = UUID_BITS + NW_BITS + NUM_THREADS + 32 + NR_BITS + 1 + NTEX_BITS
                         + (2 * NUM_THREADS * 32) + (NUM_THREADS * 32);
  localparam int AW    = $clog2(QUEUE_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int unsigned N_U = NUM_INPUTS;

  // Cyclic index (base + off) mod NUM_INPUTS, valid for off < NUM_INPUTS.
  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_U) begin
      sum = sum - N_U;
    end else begin
      sum = sum;
    end
    return SRC_W'(sum);
  endfunction

  logic [PW-1:0]        in_data_s [NUM_INPUTS];
  logic [PW-1:0]        mem_q     [NUM_INPUTS][QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q  [NUM_INPUTS];
  logic [PTR_W-1:0]     wr_ptr_d  [NUM_INPUTS];
  logic [PTR_W-1:0]     rd_ptr_q  [NUM_INPUTS];
  logic [PTR_W-1:0]     rd_ptr_d  [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] empty_s;
  logic [NUM_INPUTS-1:0] full_s;
  logic [NUM_INPUTS-1:0] push_s;
  logic [NUM_INPUTS-1:0] pop_s;

  logic [SRC_W-1:0]     grant_s;
  logic                 found_s;
  logic                 load_s;
  logic [PW-1:0]        head_s;

  logic                 out_valid_q, out_valid_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;
  logic [PW-1:0]        out_data_q, out_data_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]          perf_stalls_q, perf_stalls_d;

  // Request packing and per-FIFO status; a zero-mask request is accepted but never stored.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_data_s[i] = {in_uuid[i], in_wid[i], in_tmask[i], in_PC[i], in_rd[i], in_wb[i],
                      in_unit[i], in_coords[i], in_lod[i]};
      empty_s[i]   = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_s[i]    = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                     (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      in_ready[i]  = !full_s[i] && !reset;
      push_s[i]    = in_valid[i] && in_ready[i] && (|in_tmask[i]);
    end
  end

  // Round-robin search: first non-empty FIFO at or after rr_ptr.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    for (int unsigned k = 0; k < N_U; k++) begin
      if (!found_s && !empty_s[wrap_add(rr_ptr_q, k)]) begin
        grant_s = wrap_add(rr_ptr_q, k);
        found_s = 1'b1;
      end else begin
        grant_s = grant_s;
      end
    end
    load_s = (!out_valid_q || out_ready) && found_s;
    head_s = mem_q[grant_s][rd_ptr_q[grant_s][AW-1:0]];
  end

  // FIFO pointer advance on push/pop.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      pop_s[i] = load_s && (grant_s == SRC_W'(i));
      if (push_s[i]) begin
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
    end
  end

  // Output slot, arbitration pointer and stall counter next state.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_src_d     = out_src_q;
    out_data_d    = out_data_q;
    rr_ptr_d      = rr_ptr_q;
    perf_stalls_d = perf_stalls_q;
    if (!out_valid_q || out_ready) begin
      out_valid_d = found_s;
      if (found_s) begin
        out_src_d  = grant_s;
        out_data_d = head_s;
        rr_ptr_d   = wrap_add(grant_s, 32'd1);
      end else begin
        out_src_d  = out_src_q;
      end
    end else begin
      perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  // FIFO storage; reset needs no clear because in_ready is low while reset is high.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (push_s[i]) begin
        mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_data_s[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      out_valid_q   <= 1'b0;
      out_src_q     <= '0;
      out_data_q    <= '0;
      rr_ptr_q      <= '0;
      perf_stalls_q <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      out_valid_q   <= out_valid_d;
      out_src_q     <= out_src_d;
      out_data_q    <= out_data_d;
      rr_ptr_q      <= rr_ptr_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_src     = out_src_q;
  assign perf_stalls = perf_stalls_q;
  assign {out_uuid, out_wid, out_tmask, out_PC, out_rd, out_wb, out_unit, out_coords, out_lod} = out_data_q;

endmodule

// File: tb/tb_vx_tex_req_arb.sv
// Randomized bench for vx_tex_req_arb: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vx_tex_req_arb;
  localparam int N = 4, NT = 4, UB = 44, NWB = 2, NRB = 5, NTB = 1, QD = 4;

  typedef struct packed {
    logic [UB-1:0]            uuid;
    logic [NWB-1:0]           wid;
    logic [NT-1:0]            tmask;
    logic [31:0]              pc;
    logic [NRB-1:0]           rd;
    logic                     wb;
    logic [NTB-1:0]           unit;
    logic [1:0][NT-1:0][31:0] coords;
    logic [NT-1:0][31:0]      lod;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] in_valid;
  logic [N-1:0][UB-1:0] in_uuid;
  logic [N-1:0][NWB-1:0] in_wid;
  logic [N-1:0][NT-1:0] in_tmask;
  logic [N-1:0][31:0] in_PC;
  logic [N-1:0][NRB-1:0] in_rd;
  logic [N-1:0] in_wb;
  logic [N-1:0][NTB-1:0] in_unit;
  logic [N-1:0][1:0][NT-1:0][31:0] in_coords;
  logic [N-1:0][NT-1:0][31:0] in_lod;
  logic [N-1:0] in_ready;
  logic out_valid;
  logic [1:0] out_src;
  logic [UB-1:0] out_uuid;
  logic [NWB-1:0] out_wid;
  logic [NT-1:0] out_tmask;
  logic [31:0] out_PC;
  logic [NRB-1:0] out_rd;
  logic out_wb;
  logic [NTB-1:0] out_unit;
  logic [1:0][NT-1:0][31:0] out_coords;
  logic [NT-1:0][31:0] out_lod;
  logic out_ready;
  logic [31:0] perf_stalls;

  vx_tex_req_arb #(.NUM_INPUTS(N), .NUM_THREADS(NT), .UUID_BITS(UB), .NW_BITS(NWB),
                   .NR_BITS(NRB), .NTEX_BITS(NTB), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_PC(in_PC), .in_rd(in_rd), .in_wb(in_wb), .in_unit(in_unit),
    .in_coords(in_coords), .in_lod(in_lod), .in_ready(in_ready), .out_valid(out_valid),
    .out_src(out_src), .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask),
    .out_PC(out_PC), .out_rd(out_rd), .out_wb(out_wb), .out_unit(out_unit),
    .out_coords(out_coords), .out_lod(out_lod), .out_ready(out_ready), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic drv_reset;
  logic [N-1:0] drv_valid;
  req_t drv_req [N];
  logic drv_ready;

  req_t mq [N][$];
  logic m_ov;
  req_t m_out;
  int m_src, m_rr;
  logic [31:0] m_stalls;
  bit m_known = 1'b0;

  logic [N-1:0] last_rdy;
  logic [31:0] last_perf;
  int rec_src[$];
  logic [UB-1:0] rec_uuid[$];
  logic [NT-1:0] rec_tm[$];
  int rec_cyc[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic req_t rand_req(input logic [UB-1:0] uuid, input logic [NT-1:0] tm);
    req_t r;
    r.uuid  = uuid;
    r.wid   = NWB'($urandom);
    r.tmask = tm;
    r.pc    = $urandom;
    r.rd    = NRB'($urandom);
    r.wb    = 1'($urandom);
    r.unit  = NTB'($urandom);
    for (int a = 0; a < 2; a++)
      for (int t = 0; t < NT; t++) r.coords[a][t] = $urandom;
    for (int t = 0; t < NT; t++) r.lod[t] = $urandom;
    return r;
  endfunction

  function automatic void clear_rec();
    rec_src.delete(); rec_uuid.delete(); rec_tm.delete(); rec_cyc.delete();
  endfunction

  // One clock cycle: apply inputs, check the DUT against the model, then advance the model.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    req_t d;
    int g;
    reset = drv_reset;
    out_ready = drv_ready;
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = drv_valid[i];
      in_uuid[i]   = drv_req[i].uuid;
      in_wid[i]    = drv_req[i].wid;
      in_tmask[i]  = drv_req[i].tmask;
      in_PC[i]     = drv_req[i].pc;
      in_rd[i]     = drv_req[i].rd;
      in_wb[i]     = drv_req[i].wb;
      in_unit[i]   = drv_req[i].unit;
      in_coords[i] = drv_req[i].coords;
      in_lod[i]    = drv_req[i].lod;
    end
    #2;
    for (int i = 0; i < N; i++) exp_rdy[i] = !drv_reset && (mq[i].size() < QD);
    last_rdy  = in_ready;
    last_perf = perf_stalls;
    chk("in_ready", 512'(in_ready), 512'(exp_rdy));
    if (m_known) begin
      chk("out_valid", 512'(out_valid), 512'(m_ov));
      chk("perf_stalls", 512'(perf_stalls), 512'(m_stalls));
      if (m_ov) begin
        d.uuid = out_uuid; d.wid = out_wid; d.tmask = out_tmask; d.pc = out_PC; d.rd = out_rd;
        d.wb = out_wb; d.unit = out_unit; d.coords = out_coords; d.lod = out_lod;
        chk("out_src", 512'(out_src), 512'(m_src));
        chk("out_payload", 512'(d), 512'(m_out));
      end
    end
    if (!drv_reset && out_valid && drv_ready) begin
      rec_src.push_back(int'(out_src));
      rec_uuid.push_back(out_uuid);
      rec_tm.push_back(out_tmask);
      rec_cyc.push_back(cyc);
    end
    if (drv_reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_ov = 1'b0; m_out = '0; m_src = 0; m_rr = 0; m_stalls = 32'd0; m_known = 1'b1;
    end else begin
      if (m_ov && !drv_ready) m_stalls = m_stalls + 32'd1;
      if (!m_ov || drv_ready) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
        if (g >= 0) begin
          m_out = mq[g].pop_front(); m_src = g; m_rr = (g + 1) % N; m_ov = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
      end
      for (int i = 0; i < N; i++)
        if (exp_rdy[i] && drv_valid[i] && drv_req[i].tmask != '0) mq[i].push_back(drv_req[i]);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    drv_reset = 1'b1;
    drv_valid = '0;
    repeat (n) tick();
    drv_reset = 1'b0;
  endtask

  initial begin
    int acc, guard;
    logic [UB-1:0] uid;
    drv_reset = 1'b1; drv_ready = 1'b0; drv_valid = '0;
    for (int i = 0; i < N; i++) drv_req[i] = rand_req(UB'(i), 4'hF);

    // Reset held with every input valid.
    drv_valid = 4'b1111;
    repeat (3) tick();
    chk("t1_rdy_in_reset", 512'(in_ready), 512'(4'b0000));
    chk("t1_valid_in_reset", 512'(out_valid), 512'(1'b0));
    chk("t1_perf_in_reset", 512'(perf_stalls), 512'(32'd0));
    drv_reset = 1'b0; drv_valid = '0;
    tick();
    chk("t1_rdy_after", 512'(in_ready), 512'(4'b1111));

    // Two-cycle latency and rr pointer advance past the grant.
    do_reset(1);
    drv_ready = 1'b1;
    drv_valid = 4'b0100; drv_req[2] = rand_req(44'd5, 4'hF);
    tick();
    drv_valid = '0;
    chk("t2_valid_c1", 512'(out_valid), 512'(1'b0));
    tick();
    chk("t2_valid_c2", 512'(out_valid), 512'(1'b1));
    chk("t2_src", 512'(out_src), 512'(2'd2));
    chk("t2_uuid", 512'(out_uuid), 512'(44'd5));
    drv_valid = 4'b1001; drv_req[0] = rand_req(44'd30, 4'h1); drv_req[3] = rand_req(44'd33, 4'h8);
    tick();
    drv_valid = '0;
    tick();
    chk("t2_rr_first", 512'(out_src), 512'(2'd3));
    tick();
    chk("t2_rr_second", 512'(out_src), 512'(2'd0));

    // Round-robin over a full backlog.
    do_reset(1);
    drv_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < N; i++) drv_req[i] = rand_req(UB'(16 * i + j), NT'($urandom_range(1, 15)));
      drv_valid = 4'b1111;
      tick();
    end
    drv_valid = '0; clear_rec(); drv_ready = 1'b1;
    repeat (13) tick();
    chk("t3_count", 512'(rec_src.size()), 512'(12));
    for (int k = 0; k < 12 && k < rec_src.size(); k++) begin
      chk("t3_src", 512'(rec_src[k]), 512'(k % 4));
      chk("t3_uuid", 512'(rec_uuid[k]), 512'(16 * (k % 4) + k / 4));
      chk("t3_no_bubble", 512'(rec_cyc[k] - rec_cyc[0]), 512'(k));
    end

    // Backpressure: one held in the output, four fill the FIFO, the sixth is refused.
    do_reset(1);
    drv_ready = 1'b0; acc = 0; guard = 0;
    while (acc < 5 && guard < 20) begin
      drv_valid = 4'b0001; drv_req[0] = rand_req(UB'(100 + acc), 4'hF);
      tick();
      if (last_rdy[0]) acc++;
      guard++;
    end
    chk("t4_accepted", 512'(acc), 512'(5));
    drv_req[0] = rand_req(44'd200, 4'hF);
    tick();
    chk("t4_full_rdy", 512'(last_rdy[0]), 512'(1'b0));
    chk("t4_perf", 512'(last_perf), 512'(32'd3));
    drv_valid = '0; clear_rec(); drv_ready = 1'b1;
    repeat (8) tick();
    chk("t4_drain_count", 512'(rec_uuid.size()), 512'(5));
    for (int k = 0; k < 5 && k < rec_uuid.size(); k++)
      chk("t4_drain_uuid", 512'(rec_uuid[k]), 512'(100 + k));

    // Zero-mask request is swallowed.
    do_reset(1);
    clear_rec(); drv_ready = 1'b1;
    drv_valid = 4'b0010; drv_req[1] = rand_req(44'd50, 4'h0);
    tick();
    drv_req[1] = rand_req(44'd51, 4'h3);
    tick();
    drv_valid = '0;
    repeat (4) tick();
    chk("t5_count", 512'(rec_uuid.size()), 512'(1));
    if (rec_uuid.size() > 0) begin
      chk("t5_uuid", 512'(rec_uuid[0]), 512'(44'd51));
      chk("t5_tmask", 512'(rec_tm[0]), 512'(4'h3));
    end

    // Reset while requests are queued and one is held.
    do_reset(1);
    drv_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drv_valid = 4'b0100; drv_req[2] = rand_req(UB'(60 + j), 4'hF);
      tick();
    end
    drv_valid = '0;
    tick();
    drv_reset = 1'b1;
    tick();
    drv_reset = 1'b0;
    chk("t6_valid_after_reset", 512'(out_valid), 512'(1'b0));
    clear_rec(); drv_ready = 1'b1;
    repeat (10) tick();
    chk("t6_no_stale", 512'(rec_uuid.size()), 512'(0));

    // Random traffic with varying load, backpressure and occasional reset.
    do_reset(1);
    uid = 44'd1000;
    for (int c = 0; c < 3000; c++) begin
      int dens;
      dens = ((c / 300) % 3) + 1;
      drv_reset = ($urandom_range(0, 299) == 0);
      drv_ready = ($urandom_range(0, 3) < dens);
      for (int i = 0; i < N; i++) begin
        drv_valid[i] = ($urandom_range(0, 3) < 4 - dens);
        drv_req[i] = rand_req(uid, ($urandom_range(0, 7) == 0) ? 4'h0 : NT'($urandom_range(1, 15)));
        uid = uid + 44'd1;
      end
      tick();
    end
    drv_reset = 1'b0; drv_valid = '0; drv_ready = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
